// File: rtl/mult_exec_unit.sv
// Pipelined RV32M multiply unit: STAGES-deep partial-product accumulator that holds its result for the CDB.
// issue_entry = {valid, ready, rd_tag, rs1_value, rs2_value}; cdb_out = {valid, rob_tag, value}.
module mult_exec_unit #(
  parameter int STAGES      = 4,
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2*XLEN+ROB_TAG_LEN+1:0] issue_entry,
  input  logic [1:0]                    mul_op,
  input  logic                          squash,
  input  logic                          cdb_grant,
  output logic                          exec_stall,
  output logic                          cdb_req,
  output logic [XLEN+ROB_TAG_LEN:0]     cdb_out,
  output logic                          busy
);

  localparam int OW   = XLEN + 1;                  // extended operand width
  localparam int PW   = 2 * OW;                    // full signed product width
  localparam int CW   = (OW + STAGES - 1) / STAGES; // multiplier chunk per stage
  localparam int BW   = CW * STAGES;
  localparam int LAST = STAGES - 1;

  // Chunk idx of the sign-extended multiplier times the multiplicand, mod 2^PW.
  // Only the top chunk carries the multiplier's sign.
  function automatic logic [PW-1:0] partial(input logic [OW-1:0] a, input logic [BW-1:0] b,
                                            input int idx);
    logic [CW-1:0] chunk;
    logic [PW-1:0] a_w;
    logic [PW-1:0] c_w;
    chunk = b[idx*CW +: CW];
    a_w   = PW'($signed(a));
    if (idx == STAGES - 1) c_w = PW'($signed(chunk));
    else                   c_w = PW'(chunk);
    return (a_w * c_w) << (idx * CW);
  endfunction

  logic                   in_vld;
  logic                   in_rdy;
  logic [ROB_TAG_LEN-1:0] in_tag;
  logic [XLEN-1:0]        rs1;
  logic [XLEN-1:0]        rs2;
  logic                   rs1_sgn;
  logic                   rs2_sgn;
  logic signed [OW-1:0]   a_ext;
  logic signed [OW-1:0]   b_ext;
  logic [BW-1:0]          b_wide;

  assign in_vld  = issue_entry[2*XLEN+ROB_TAG_LEN+1];
  assign in_rdy  = issue_entry[2*XLEN+ROB_TAG_LEN];
  assign in_tag  = issue_entry[2*XLEN +: ROB_TAG_LEN];
  assign rs1     = issue_entry[XLEN +: XLEN];
  assign rs2     = issue_entry[0 +: XLEN];
  assign rs1_sgn = (mul_op != 2'd3);
  assign rs2_sgn = (mul_op == 2'd0) || (mul_op == 2'd1);
  assign a_ext   = {rs1_sgn & rs1[XLEN-1], rs1};
  assign b_ext   = {rs2_sgn & rs2[XLEN-1], rs2};
  assign b_wide  = BW'(b_ext);

  logic [STAGES-1:0]      vld;
  logic [ROB_TAG_LEN-1:0] tag [STAGES];
  logic [1:0]             op  [STAGES];
  logic [OW-1:0]          opa [STAGES];
  logic [BW-1:0]          opb [STAGES];
  logic [PW-1:0]          acc [STAGES];

  logic fin_vld;
  logic advance;
  logic accept;
  logic [XLEN-1:0] result;

  assign fin_vld    = vld[LAST];
  assign advance    = ~(fin_vld & ~cdb_grant);
  assign exec_stall = fin_vld & ~cdb_grant;
  assign accept     = in_vld & in_rdy & ~exec_stall & ~squash;

  // Global freeze: either every stage moves or none does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int s = 0; s < STAGES; s++) begin
        tag[s] <= '0;
        op[s]  <= '0;
        opa[s] <= '0;
        opb[s] <= '0;
        acc[s] <= '0;
      end
    end else begin
      if (squash) begin
        vld <= '0;
      end else if (advance) begin
        vld[0] <= accept;
        for (int s = 1; s < STAGES; s++) vld[s] <= vld[s-1];
      end
      if (advance) begin
        if (accept) begin
          tag[0] <= in_tag;
          op[0]  <= mul_op;
          opa[0] <= a_ext;
          opb[0] <= b_wide;
          acc[0] <= partial(a_ext, b_wide, 0);
        end
        for (int s = 1; s < STAGES; s++) begin
          tag[s] <= tag[s-1];
          op[s]  <= op[s-1];
          opa[s] <= opa[s-1];
          opb[s] <= opb[s-1];
          acc[s] <= acc[s-1] + partial(opa[s-1], opb[s-1], s);
        end
      end
    end
  end

  assign result  = (op[LAST] == 2'd0) ? acc[LAST][XLEN-1:0] : acc[LAST][2*XLEN-1:XLEN];
  assign cdb_req = fin_vld;
  assign cdb_out = fin_vld ? {cdb_grant, tag[LAST], result} : '0;
  assign busy    = |vld;

endmodule

// File: tb/tb_mult_exec_unit.sv
// Bench for mult_exec_unit: directed scenarios on a 4-stage unit, then a random sweep
// across 1/2/4/8-stage instances against a 64-bit arithmetic reference.
module tb_mult_exec_unit;
  localparam int XLEN    = 32;
  localparam int TAGW    = 6;
  localparam int ENTRY_W = 2 + TAGW + 2*XLEN;
  localparam int CDB_W   = 1 + TAGW + XLEN;
  localparam int NDUT    = 4;
  localparam int NCYC    = 300;
  localparam int NISS    = 280;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [ENTRY_W-1:0] issue_entry;
  logic [1:0]         mul_op;
  logic               squash;
  logic               cdb_grant;
  logic               stall_o [NDUT];
  logic               req_o   [NDUT];
  logic               busy_o  [NDUT];
  logic [CDB_W-1:0]   cdb_o   [NDUT];

  always #5 clk = ~clk;

  function automatic int stages_of(input int g);
    return (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mult_exec_unit #(.STAGES(stages_of(g)), .XLEN(XLEN), .ROB_TAG_LEN(TAGW)) u_dut (
      .clk(clk), .reset(rst_n), .issue_entry(issue_entry), .mul_op(mul_op),
      .squash(squash), .cdb_grant(cdb_grant), .exec_stall(stall_o[g]),
      .cdb_req(req_o[g]), .cdb_out(cdb_o[g]), .busy(busy_o[g]));
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: true 64-bit product of the operands read per the op's signedness.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
    longint a, b, p;
    a = (op != 2'd3) ? longint'($signed(x)) : longint'({32'b0, x});
    b = (op <= 2'd1) ? longint'($signed(y)) : longint'({32'b0, y});
    p = a * b;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  // Scoreboard for the 4-stage unit: expected broadcasts in issue order.
  logic [TAGW+XLEN-1:0] exp_q[$];
  logic [TAGW+XLEN-1:0] mon_e;
  bit mon_en = 1'b0;
  int cyc = 0;
  int seen_cnt = 0;
  int seen_cyc = 0;
  int stall_cnt = 0;
  int req_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && rst_n === 1'b1 && cdb_o[0][CDB_W-1] === 1'b1) begin
      seen_cnt++;
      seen_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_broadcast", 64'(cdb_o[0][XLEN +: TAGW]), 64'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("cdb_tag", 64'(cdb_o[0][XLEN +: TAGW]), 64'(mon_e[XLEN +: TAGW]));
        check("cdb_value", 64'(cdb_o[0][XLEN-1:0]), 64'(mon_e[XLEN-1:0]));
      end
    end
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      stall_cnt += int'(stall_o[0]);
      req_cnt   += int'(req_o[0]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [TAGW-1:0] tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    issue_entry = {1'b1, 1'b1, tag, a, b};
    mul_op      = op;
  endtask

  task automatic idle();
    issue_entry = '0;
    mul_op      = 2'd0;
    squash      = 1'b0;
  endtask

  task automatic push_exp(input logic [TAGW-1:0] tag, input logic [31:0] val);
    exp_q.push_back({tag, val});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] sign_exp [4];
  int base_seen;
  int c0;
  bit acc_q [NCYC];
  logic [TAGW-1:0] t_q [NCYC];
  logic [31:0] v_q [NCYC];

  initial begin
    sign_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    rst_n = 1'b0;
    cdb_grant = 1'b0;
    idle();
    #12;
    check("reset_stall", 64'(stall_o[0]), 64'd0);
    check("reset_req", 64'(req_o[0]), 64'd0);
    check("reset_cdb", 64'(cdb_o[0]), 64'd0);
    check("reset_busy", 64'(busy_o[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single MUL 7*6, tag 3, continuous grant
    cdb_grant = 1'b1;
    stall_cnt = 0;
    base_seen = seen_cnt;
    c0 = cyc;
    issue(6'd3, 2'd0, 32'd7, 32'd6);
    push_exp(6'd3, 32'd42);
    wait_cycles(1);
    idle();
    wait_cycles(8);
    check("single_count", 64'(seen_cnt - base_seen), 64'd1);
    check("single_latency", 64'(seen_cyc - c0), 64'd4);
    check("single_no_stall", 64'(stall_cnt), 64'd0);
    check("single_drained", 64'(exp_q.size()), 64'd0);

    // Sign handling across the four ops
    base_seen = seen_cnt;
    for (int k = 0; k < 4; k++) begin
      issue(6'(8 + k), 2'(k), 32'hFFFF_FFFF, 32'd2);
      push_exp(6'(8 + k), sign_exp[k]);
      wait_cycles(1);
    end
    idle();
    wait_cycles(8);
    check("sign_count", 64'(seen_cnt - base_seen), 64'd4);
    check("sign_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back tags 1..4, grant withheld 3 cycles while tag 1 is final
    base_seen = seen_cnt;
    stall_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      issue(6'(k), 2'd0, 32'(2*k), 32'(2*k + 1));
      push_exp(6'(k), ref_mul(2'd0, 32'(2*k), 32'(2*k + 1)));
      wait_cycles(1);
    end
    idle();
    cdb_grant = 1'b0;
    check("hold_req_high", 64'(req_o[0]), 64'd1);
    wait_cycles(3);
    cdb_grant = 1'b1;
    wait_cycles(8);
    check("hold_stall_cycles", 64'(stall_cnt), 64'd3);
    check("b2b_count", 64'(seen_cnt - base_seen), 64'd4);
    check("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Squash with 3 in flight plus a simultaneous accept
    base_seen = seen_cnt;
    for (int k = 0; k < 3; k++) begin
      issue(6'(20 + k), 2'd0, 32'(k + 1), 32'd3);
      wait_cycles(1);
    end
    issue(6'd23, 2'd0, 32'd9, 32'd9);
    squash = 1'b1;
    wait_cycles(1);
    idle();
    check("squash_busy", 64'(busy_o[0]), 64'd0);
    req_cnt = 0;
    wait_cycles(8);
    check("squash_no_req", 64'(req_cnt), 64'd0);
    issue(6'd24, 2'd0, 32'd5, 32'd9);
    push_exp(6'd24, 32'd45);
    wait_cycles(1);
    idle();
    wait_cycles(8);
    check("post_squash_count", 64'(seen_cnt - base_seen), 64'd1);
    check("post_squash_drained", 64'(exp_q.size()), 64'd0);

    // Async reset mid-pipe with grant low
    cdb_grant = 1'b0;
    issue(6'd30, 2'd0, 32'd11, 32'd12);
    wait_cycles(1);
    issue(6'd31, 2'd0, 32'd13, 32'd14);
    wait_cycles(1);
    idle();
    wait_cycles(2);
    check("pre_reset_req", 64'(req_o[0]), 64'd1);
    check("pre_reset_stall", 64'(stall_o[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_stall", 64'(stall_o[0]), 64'd0);
    check("async_reset_req", 64'(req_o[0]), 64'd0);
    check("async_reset_cdb", 64'(cdb_o[0]), 64'd0);
    check("async_reset_busy", 64'(busy_o[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base_seen = seen_cnt;
    cdb_grant = 1'b1;
    issue(6'd5, 2'd0, 32'h0001_0000, 32'h0001_0000);
    push_exp(6'd5, 32'd0);
    wait_cycles(1);
    issue(6'd6, 2'd3, 32'h0001_0000, 32'h0001_0000);
    push_exp(6'd6, 32'd1);
    wait_cycles(1);
    idle();
    wait_cycles(8);
    check("post_reset_count", 64'(seen_cnt - base_seen), 64'd2);
    check("post_reset_drained", 64'(exp_q.size()), 64'd0);

    // Random sweep over all depths, continuous grant
    mon_en = 1'b0;
    rst_n = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
    cdb_grant = 1'b1;
    for (int j = 0; j < NCYC; j++) begin
      if (j < NISS) begin
        logic v, r;
        logic [1:0] op;
        logic [TAGW-1:0] tg;
        logic [31:0] a, b;
        v  = ($urandom_range(0, 3) != 0);
        r  = ($urandom_range(0, 7) != 0);
        op = 2'($urandom_range(0, 3));
        tg = 6'($urandom_range(0, 63));
        a  = pick_operand();
        b  = pick_operand();
        issue_entry = {v, r, tg, a, b};
        mul_op = op;
        acc_q[j] = v & r;
        t_q[j] = tg;
        v_q[j] = ref_mul(op, a, b);
      end else begin
        idle();
        acc_q[j] = 1'b0;
        t_q[j] = '0;
        v_q[j] = '0;
      end
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        int s;
        bit ev;
        s  = stages_of(g);
        ev = (j >= s) ? acc_q[j - s] : 1'b0;
        check($sformatf("sweep_s%0d_valid_c%0d", s, j), 64'(cdb_o[g][CDB_W-1]), 64'(ev));
        if (ev) begin
          check($sformatf("sweep_s%0d_tag_c%0d", s, j), 64'(cdb_o[g][XLEN +: TAGW]),
                64'(t_q[j - s]));
          check($sformatf("sweep_s%0d_value_c%0d", s, j), 64'(cdb_o[g][XLEN-1:0]),
                64'(v_q[j - s]));
        end
        if (stall_o[g] !== 1'b0)
          check($sformatf("sweep_s%0d_stall_c%0d", s, j), 64'(stall_o[g]), 64'd0);
      end
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_exec_unit.md
# mult_exec_unit

Pipelined integer multiply functional unit sitting directly downstream of the ALU reservation station. It accepts the issued entry (`INSTR_READY_ENTRY`) the station presents, computes the RV32M product over `STAGES` cycles, and holds the finished result until the CDB arbiter grants a broadcast. When the result cannot drain it back-pressures the station through `exec_stall`.

## Interface
- `STAGES`, 4: pipeline depth in cycles, issue to result; legal values are 1, 2, 4 and 8.
- `XLEN`, 32: operand and result width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `issue_entry`  in  `INSTR_READY_ENTRY`  issued instruction; uses `valid`, `ready`, `rd_tag`, `rs1_value`, `rs2_value`.
- `mul_op`  in  2  operation select, sampled with `issue_entry`: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
- `squash`  in  1  mispredict flush; kills every in-flight operation.
- `cdb_grant`  in  1  arbiter grant for this unit's request, same cycle.
- `exec_stall`  out  1  to the reservation station; the unit cannot accept this cycle.
- `cdb_req`  out  1  a result is waiting to broadcast.
- `cdb_out`  out  `CDB_DATA`  the broadcast packet: `valid`, `rob_tag` (`ROB_TAG_LEN`), `value` (`XLEN`).
- `busy`  out  1  at least one stage holds a valid operation (debug and perf use).

## Operation
- **Accept:** `issue_entry.valid & issue_entry.ready & ~exec_stall & ~squash`. Stage 0 captures the tag, the op, and the two operands extended to 33 bits:
  - rs1 is signed for MUL, MULH and MULHSU.
  - rs2 is signed for MUL and MULH.
  - All other cases zero-extend.
- **Arithmetic:**
  - Form the 66-bit signed product of the two 33-bit operands.
  - Split the multiplier operand into `STAGES` equal chunks. Each stage adds one chunk's shifted partial product into an accumulator.
  - The final stage holds the full product.
  - Result selection: MUL takes product[31:0]; MULH, MULHSU and MULHU take product[63:32].
- **Pipeline register per stage:** `valid`, `rob_tag`, `op`, operands, accumulator.
- **Advance rule:** the whole pipe advances when `~(final.valid & ~cdb_grant)`. Otherwise every stage holds (global freeze, no bubble collapse).
- **exec_stall:** `final.valid & ~cdb_grant`. This is combinational, so the station sees the stall in the same cycle.
- **CDB outputs:**
  - `cdb_req = final.valid`.
  - `cdb_out.valid = final.valid & cdb_grant`.
  - `cdb_out.rob_tag` and `cdb_out.value` come from the final stage and are zero when the final stage is invalid.
- **On grant:** the final stage retires and the pipe advances in that same edge.
- **Squash:** at the next edge every stage valid clears. An accept in the same cycle is dropped. `cdb_req`, `cdb_out` and `exec_stall` still reflect the pre-squash state for the squash cycle only.
- **Squash while granted:** the granted broadcast still completes (`cdb_out.valid = 1`) in that cycle.
- **Throughput:** one operation per cycle when never stalled.

## Timing
- **Reset** (asynchronous, `reset = 0`): all stage valids 0 and datapath registers 0. Hence `exec_stall = 0`, `cdb_req = 0`, `cdb_out = 0`, `busy = 0`.
- **Reset mid-operation:** in-flight work is lost and no broadcast occurs.
- **Latency:**
  - An op accepted at edge N is in the final stage after edge N+`STAGES`-1.
  - `cdb_req` rises in the following cycle.
  - Example with `STAGES = 4`: accept at edge 0, request visible from edge 3 to edge 4.
- **Grant arrives in the request cycle:** the result broadcasts that cycle and the next op may be accepted in the same cycle.
- **Grant withheld for k cycles:** `exec_stall` stays high for exactly those k cycles and the pipe contents are unchanged.
- **Back-to-back:** ops accepted on consecutive edges reach the CDB on consecutive cycles, in issue order, provided grants are continuous.
- **Empty pipe:** `exec_stall = 0` regardless of `cdb_grant`.
- **Full pipe (all stages valid) with continuous grant:** the unit still accepts; it never stalls.

## Test plan
- **Reset, then a single MUL.** rs1 = 7, rs2 = 6, tag 3, grant held at 1 → after `STAGES` cycles, one cycle with `cdb_out.valid = 1`, `rob_tag = 3`, `value = 42`. `exec_stall` is never asserted.
- **Sign-handling sweep, rs1 = 0xFFFFFFFF, rs2 = 2** → MUL = 0xFFFFFFFE, MULH = 0xFFFFFFFF, MULHSU = 0xFFFFFFFF, MULHU = 0x00000001.
- **Back-to-back issue of tags 1, 2, 3, 4** (products 2·3, 4·5, 6·7, 8·9) with grant low for 3 cycles while tag 1 is final → `exec_stall` high for exactly 3 cycles. Tags then broadcast in order 1–4 with values 6, 20, 42, 72, and no op is lost or duplicated.
- **Squash with 3 ops in flight plus a simultaneous accept** → no subsequent `cdb_req`; `busy = 0` after one edge; the next issue completes normally.
- **Async reset asserted mid-pipe** (asynchronously, between edges) with 2 ops valid and grant low → outputs zero immediately. After release, a new MUL 0x10000 × 0x10000 returns 0 (MUL) and 1 (MULHU).
- **Parameter sweep `STAGES = 1, 2, 8`** with random operands against a 64-bit reference model → latency equals `STAGES` and all values match.
